// File: rtl/wide_to_word_unpacker_if.sv
// rtl/wide_to_word_unpacker_if.sv - wide block in / narrow word stream out handshake bundle
interface wide_to_word_unpacker_if #(
    parameter int WIDE_WIDTH = 1024,
    parameter int WORD_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
);
    logic [WIDE_WIDTH-1:0] wide_din;
    logic                  wide_din_valid;
    logic                  wide_din_read;
    logic [WORD_WIDTH-1:0] word_dout;
    logic                  word_dout_valid;
    logic                  word_dout_ready;
    logic [IDX_WIDTH-1:0]  word_index;
    logic                  block_done;

    // Master is the surrounding system: block producer plus word consumer.
    modport master (
        output wide_din, wide_din_valid, word_dout_ready,
        input  wide_din_read, word_dout, word_dout_valid, word_index, block_done
    );

    modport slave (
        input  wide_din, wide_din_valid, word_dout_ready,
        output wide_din_read, word_dout, word_dout_valid, word_index, block_done
    );
endinterface

// File: rtl/wide_to_word_unpacker.sv
// rtl/wide_to_word_unpacker.sv - unpacks one wide result block into a stream of narrow words, LSW first
module wide_to_word_unpacker #(
    parameter int WIDE_WIDTH = 1024,
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = WIDE_WIDTH / WORD_WIDTH,
    parameter int IDX_WIDTH  = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic busy,
    wide_to_word_unpacker_if.slave bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORD_COUNT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDE_WIDTH-1:0] shift_q;
    logic [IDX_WIDTH-1:0]  index_q;
    logic                  read_q;
    logic                  done_q;
    logic                  capture;
    logic                  xfer;
    logic                  last_xfer;

    assign capture   = (state == IDLE) && bus.wide_din_valid && !clear;
    assign xfer      = (state == SEND) && bus.word_dout_ready && !clear;
    assign last_xfer = xfer && (index_q == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.wide_din_valid) state_next = SEND;
                SEND:    if (last_xfer) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.word_dout_valid = 1'b0;
        busy                = 1'b0;
        if (state == SEND) begin
            bus.word_dout_valid = 1'b1;
            busy                = 1'b1;
        end
    end

    // The register and index are zero whenever SEND is left, so the word outputs
    // read 0 while not valid without any extra gating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= '0;
            index_q <= '0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            read_q <= capture;
            done_q <= last_xfer;
            if (clear) begin
                shift_q <= '0;
                index_q <= '0;
            end else if (capture) begin
                shift_q <= bus.wide_din;
                index_q <= '0;
            end else if (xfer) begin
                shift_q <= shift_q >> WORD_WIDTH;
                index_q <= last_xfer ? '0 : index_q + IDX_WIDTH'(1);
            end
        end
    end

    assign bus.word_dout     = shift_q[WORD_WIDTH-1:0];
    assign bus.word_index    = index_q;
    assign bus.wide_din_read = read_q;
    assign bus.block_done    = done_q;
endmodule
